// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and ID writeback,
// with a per-register pending-write scoreboard that drives the RAW stall.
module reg_wb_arbiter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 3,
   parameter int unsigned NUM_REGS = 8,
   parameter int unsigned ZERO_REG = 7,
   parameter int unsigned PEND_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_wr_valid,
   input  logic [ADDR_W-1:0] alu_wr_addr,
   input  logic [DATA_W-1:0] alu_wr_data,
   output logic              alu_wr_ready,
   input  logic              id_wr_valid,
   input  logic [ADDR_W-1:0] id_wr_addr,
   input  logic [DATA_W-1:0] id_wr_data,
   output logic              id_wr_ready,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic [ADDR_W-1:0] chk_addr1,
   input  logic [ADDR_W-1:0] chk_addr2,
   output logic              raw_stall,
   output logic              rf_write_enable,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_value_alu,
   output logic [DATA_W-1:0] rf_write_value_id,
   output logic              rf_write_data_sel,
   output logic              sb_overflow
);

   localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);
   localparam logic [PEND_W-1:0] PendMax  = '1;

   logic                last_alu_q, last_alu_d;
   logic                grant_alu, grant_id, grant_nonzero;
   logic                ovf_d;
   logic [NUM_REGS-1:0] inc_vec, dec_vec;
   logic [PEND_W-1:0]   cnt_q [NUM_REGS];
   logic [PEND_W-1:0]   cnt_d [NUM_REGS];

   // last_alu_q = 0 means ID won the last conflict, so ALU wins the next one.
   always_comb begin
      grant_alu     = alu_wr_valid & (~id_wr_valid | ~last_alu_q);
      grant_id      = id_wr_valid & ~grant_alu;
      alu_wr_ready  = grant_alu;
      id_wr_ready   = grant_id;
      last_alu_d    = last_alu_q;
      if (alu_wr_valid && id_wr_valid) begin
         last_alu_d = grant_alu;
      end
      grant_nonzero = (grant_alu && (alu_wr_addr != ZeroAddr)) ||
                      (grant_id && (id_wr_addr != ZeroAddr));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_alu_q         <= 1'b0;
         rf_write_enable    <= 1'b0;
         rf_write_addr      <= '0;
         rf_write_value_alu <= '0;
         rf_write_value_id  <= '0;
         rf_write_data_sel  <= 1'b0;
      end else begin
         last_alu_q      <= last_alu_d;
         rf_write_enable <= grant_nonzero;
         if (grant_alu) begin
            rf_write_addr      <= alu_wr_addr;
            rf_write_value_alu <= alu_wr_data;
            rf_write_data_sel  <= 1'b1;
         end else if (grant_id) begin
            rf_write_addr      <= id_wr_addr;
            rf_write_value_id  <= id_wr_data;
            rf_write_data_sel  <= 1'b0;
         end
      end
   end

   // Retire happens on the edge the register file writes, i.e. while rf_write_enable is high.
   always_comb begin
      ovf_d = sb_overflow;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         inc_vec[r] = issue_valid && (issue_addr == ADDR_W'(r)) && (issue_addr != ZeroAddr);
         dec_vec[r] = rf_write_enable && (rf_write_addr == ADDR_W'(r));
         cnt_d[r]   = cnt_q[r];
         if (inc_vec[r] && !dec_vec[r]) begin
            if (cnt_q[r] == PendMax) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] + PEND_W'(1);
            end
         end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
            cnt_d[r] = cnt_q[r] - PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_overflow <= 1'b0;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         sb_overflow <= ovf_d;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   always_comb begin
      raw_stall = ((chk_addr1 != ZeroAddr) && (cnt_q[chk_addr1] != '0)) ||
                  ((chk_addr2 != ZeroAddr) && (cnt_q[chk_addr2] != '0));
   end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_reg_wb_arbiter;

   localparam int ZR = 7;
   localparam int PMAX = 3;

   logic        clk, rst_n;
   logic        alu_wr_valid, id_wr_valid, issue_valid;
   logic [2:0]  alu_wr_addr, id_wr_addr, issue_addr, chk_addr1, chk_addr2;
   logic [31:0] alu_wr_data, id_wr_data;
   logic        alu_wr_ready, id_wr_ready, raw_stall;
   logic        rf_write_enable, rf_write_data_sel, sb_overflow;
   logic [2:0]  rf_write_addr;
   logic [31:0] rf_write_value_alu, rf_write_value_id;

   int n_err = 0;
   int n_checks = 0;

   reg_wb_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .alu_wr_valid(alu_wr_valid), .alu_wr_addr(alu_wr_addr), .alu_wr_data(alu_wr_data),
      .alu_wr_ready(alu_wr_ready),
      .id_wr_valid(id_wr_valid), .id_wr_addr(id_wr_addr), .id_wr_data(id_wr_data),
      .id_wr_ready(id_wr_ready),
      .issue_valid(issue_valid), .issue_addr(issue_addr),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .raw_stall(raw_stall),
      .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
      .rf_write_value_alu(rf_write_value_alu), .rf_write_value_id(rf_write_value_id),
      .rf_write_data_sel(rf_write_data_sel), .sb_overflow(sb_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: who won the last tie, pending counts, and the write in flight.
   bit          m_alu_won_tie;
   int          m_cnt [8];
   bit          m_ovf, m_we, m_sel, m_hs_alu, m_hs_id;
   int          m_addr;
   logic [31:0] m_valu, m_vid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_alu_won_tie = 0; m_ovf = 0; m_we = 0; m_sel = 0; m_addr = 0;
         m_valu = 0; m_vid = 0; m_hs_alu = 0; m_hs_id = 0;
         foreach (m_cnt[r]) m_cnt[r] = 0;
      end else begin
         bit ga, gi;
         if (alu_wr_valid && id_wr_valid) begin
            ga = !m_alu_won_tie;
            m_alu_won_tie = ga;
         end else begin
            ga = alu_wr_valid;
         end
         gi = id_wr_valid && !ga;
         foreach (m_cnt[r]) begin
            int delta;
            delta = 0;
            if (issue_valid && int'(issue_addr) == r && r != ZR) delta++;
            if (m_we && m_addr == r) delta--;
            if (delta > 0) begin
               if (m_cnt[r] == PMAX) m_ovf = 1;
               else m_cnt[r]++;
            end else if (delta < 0 && m_cnt[r] > 0) begin
               m_cnt[r]--;
            end
         end
         m_we = 0;
         if (ga) begin
            m_we = int'(alu_wr_addr) != ZR; m_addr = int'(alu_wr_addr);
            m_sel = 1; m_valu = alu_wr_data;
         end else if (gi) begin
            m_we = int'(id_wr_addr) != ZR; m_addr = int'(id_wr_addr);
            m_sel = 0; m_vid = id_wr_data;
         end
         m_hs_alu = ga; m_hs_id = gi;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         bit ea;
         bit stall;
         ea = alu_wr_valid && !(id_wr_valid && m_alu_won_tie);
         stall = (int'(chk_addr1) != ZR && m_cnt[chk_addr1] > 0) ||
                 (int'(chk_addr2) != ZR && m_cnt[chk_addr2] > 0);
         chk("m_alu_ready", 64'(alu_wr_ready), 64'(ea));
         chk("m_id_ready", 64'(id_wr_ready), 64'(id_wr_valid && !ea));
         chk("m_we", 64'(rf_write_enable), 64'(m_we));
         chk("m_addr", 64'(rf_write_addr), 64'(m_addr));
         chk("m_sel", 64'(rf_write_data_sel), 64'(m_sel));
         chk("m_valu", 64'(rf_write_value_alu), 64'(m_valu));
         chk("m_vid", 64'(rf_write_value_id), 64'(m_vid));
         chk("m_raw", 64'(raw_stall), 64'(stall));
         chk("m_ovf", 64'(sb_overflow), 64'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 0; alu_wr_valid = 0; id_wr_valid = 0; issue_valid = 0;
      alu_wr_addr = 0; id_wr_addr = 0; issue_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
      alu_wr_data = 0; id_wr_data = 0;
      repeat (2) tick();
      rst_n = 1;
      tick();

      // Single ALU write
      alu_wr_valid = 1; alu_wr_addr = 3; alu_wr_data = 32'hDEADBEEF;
      at_neg(); chk("single_ready", 64'(alu_wr_ready), 64'd1);
      tick(); alu_wr_valid = 0;
      at_neg();
      chk("single_we", 64'(rf_write_enable), 64'd1);
      chk("single_addr", 64'(rf_write_addr), 64'd3);
      chk("single_sel", 64'(rf_write_data_sel), 64'd1);
      chk("single_val", 64'(rf_write_value_alu), 64'hDEADBEEF);
      tick();

      // Contention: grants alternate ALU, ID, ALU, ID
      alu_wr_valid = 1; alu_wr_addr = 1; alu_wr_data = 32'hA1;
      id_wr_valid = 1;  id_wr_addr = 2;  id_wr_data = 32'hB2;
      for (int i = 0; i < 4; i++) begin
         at_neg();
         chk("cont_alu_ready", 64'(alu_wr_ready), 64'(i % 2 == 0));
         chk("cont_id_ready", 64'(id_wr_ready), 64'(i % 2 == 1));
         if (i > 0) chk("cont_sel", 64'(rf_write_data_sel), 64'((i - 1) % 2 == 0));
         tick();
      end
      alu_wr_valid = 0; id_wr_valid = 0;
      at_neg(); chk("cont_sel_last", 64'(rf_write_data_sel), 64'd0);
      tick();

      // Zero register
      id_wr_valid = 1; id_wr_addr = 7; id_wr_data = 32'h55;
      at_neg(); chk("zero_ready", 64'(id_wr_ready), 64'd1);
      tick(); id_wr_valid = 0;
      at_neg(); chk("zero_we", 64'(rf_write_enable), 64'd0);
      issue_valid = 1; issue_addr = 7;
      tick(); issue_valid = 0; chk_addr1 = 7;
      at_neg(); chk("zero_raw", 64'(raw_stall), 64'd0);
      tick();

      // Scoreboard: issue then retire
      issue_valid = 1; issue_addr = 5;
      tick(); issue_valid = 0; chk_addr1 = 0; chk_addr2 = 5;
      at_neg(); chk("sb_pending", 64'(raw_stall), 64'd1);
      alu_wr_valid = 1; alu_wr_addr = 5; alu_wr_data = 32'h5;
      tick(); alu_wr_valid = 0;
      at_neg();
      chk("sb_we", 64'(rf_write_enable), 64'd1);
      chk("sb_still", 64'(raw_stall), 64'd1);
      tick();
      at_neg(); chk("sb_retired", 64'(raw_stall), 64'd0);
      // Same-edge issue and retire on a count of 1
      issue_valid = 1; issue_addr = 5;
      tick(); issue_valid = 0;
      alu_wr_valid = 1;
      tick(); alu_wr_valid = 0; issue_valid = 1;
      tick(); issue_valid = 0;
      at_neg(); chk("sb_same_edge", 64'(raw_stall), 64'd1);

      // Async reset mid-cycle drops an in-flight write
      alu_wr_valid = 1; alu_wr_addr = 6;
      tick(); alu_wr_valid = 0;
      at_neg(); chk("rst_pre_we", 64'(rf_write_enable), 64'd1);
      #2 rst_n = 0;
      #1;
      chk("rst_we", 64'(rf_write_enable), 64'd0);
      chk("rst_raw", 64'(raw_stall), 64'd0);
      chk("rst_alu_ready", 64'(alu_wr_ready), 64'd0);
      chk("rst_id_ready", 64'(id_wr_ready), 64'd0);
      chk("rst_ovf", 64'(sb_overflow), 64'd0);
      tick(); rst_n = 1;
      tick();

      // Overflow: four issues to reg 4, counter saturates at 3
      chk_addr2 = 4;
      issue_valid = 1; issue_addr = 4;
      repeat (3) tick();
      at_neg(); chk("ovf_not_yet", 64'(sb_overflow), 64'd0);
      tick(); issue_valid = 0;
      at_neg(); chk("ovf_set", 64'(sb_overflow), 64'd1);
      alu_wr_valid = 1; alu_wr_addr = 4;
      repeat (3) tick();
      alu_wr_valid = 0;
      at_neg(); chk("ovf_cnt_one_left", 64'(raw_stall), 64'd1);
      tick();
      at_neg();
      chk("ovf_cnt_drained", 64'(raw_stall), 64'd0);
      chk("ovf_sticky", 64'(sb_overflow), 64'd1);
      #2 rst_n = 0;
      #1 chk("ovf_cleared", 64'(sb_overflow), 64'd0);
      tick(); rst_n = 1;
      tick();

      // Randomized traffic; requesters hold their request until granted
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            #2 rst_n = 0;
            tick(); rst_n = 1;
            alu_wr_valid = 0; id_wr_valid = 0;
         end
         if (!alu_wr_valid || m_hs_alu) begin
            alu_wr_valid = ($urandom_range(0, 2) != 0);
            alu_wr_addr = 3'($urandom_range(0, 7));
            alu_wr_data = $urandom;
         end
         if (!id_wr_valid || m_hs_id) begin
            id_wr_valid = ($urandom_range(0, 2) != 0);
            id_wr_addr = 3'($urandom_range(0, 7));
            id_wr_data = $urandom;
         end
         issue_valid = ($urandom_range(0, 3) == 0);
         issue_addr = 3'($urandom_range(0, 7));
         chk_addr1 = 3'($urandom_range(0, 7));
         chk_addr2 = 3'($urandom_range(0, 7));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
